// File: rtl/add_seq_pkg.sv
// Shared types and constants for the byte-serial add/subtract sequencer.
package add_seq_pkg;

   localparam int NUM_BYTES_DEF = 4;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/conditional_sum_adder.sv
// 8-bit conditional-sum adder: both upper-nibble sums are formed in parallel
// and the lower-nibble carry selects between them.
module conditional_sum_adder (
   input  logic [7:0] x,
   input  logic [7:0] y,
   input  logic       c0,
   output logic [7:0] S,
   output logic       c8
);

   logic [4:0] lo;
   logic [4:0] hi0;
   logic [4:0] hi1;

   assign lo  = {1'b0, x[3:0]} + {1'b0, y[3:0]} + {4'b0, c0};
   assign hi0 = {1'b0, x[7:4]} + {1'b0, y[7:4]};
   assign hi1 = {1'b0, x[7:4]} + {1'b0, y[7:4]} + 5'd1;

   assign S  = {(lo[4] ? hi1[3:0] : hi0[3:0]), lo[3:0]};
   assign c8 = lo[4] ? hi1[4] : hi0[4];

endmodule

// File: rtl/add_sequencer.sv
// Two-requester byte-serial adder sharing one 8-bit adder, round-robin arbitrated.
// Define ADD_SEQ_SUB_EN to honour reqN_op (subtract); otherwise every request adds.
//
// state | meaning
// IDLE  | waiting for a request; ready raised for the granted requester
// RUN   | one byte per cycle through the shared adder, LSB first
// DONE  | result registered onto rsp_*, held until rsp_ready
module add_sequencer
   import add_seq_pkg::*;
#(
   parameter int NUM_BYTES = NUM_BYTES_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req0_valid,
   output logic                   req0_ready,
   input  logic [8*NUM_BYTES-1:0] req0_a,
   input  logic [8*NUM_BYTES-1:0] req0_b,
   input  logic                   req0_op,
   input  logic                   req1_valid,
   output logic                   req1_ready,
   input  logic [8*NUM_BYTES-1:0] req1_a,
   input  logic [8*NUM_BYTES-1:0] req1_b,
   input  logic                   req1_op,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [8*NUM_BYTES-1:0] rsp_sum,
   output logic                   rsp_cout,
   output logic                   rsp_id
);

   localparam int W  = 8 * NUM_BYTES;
   localparam int CW = $clog2(NUM_BYTES);
   localparam logic [CW-1:0] CNT_LAST = CW'(NUM_BYTES - 1);

   state_t        state;
   logic          prio;
   logic          grant_id;
   logic          accept;
   logic          sub_in;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [W-1:0]  sum_q;
   logic          carry_q;
   logic          id_q;
   logic [CW-1:0] cnt;
   logic [7:0]    add_y;
   logic [7:0]    add_s;
   logic          add_c8;

   // prio = 1 favours requester 1 when both are valid
   always_comb begin
      grant_id = 1'b0;
      if (req1_valid && (!req0_valid || prio)) grant_id = 1'b1;
   end

   // Gated by rst_n so ready is low throughout reset even though state is IDLE.
   assign req0_ready = rst_n && (state == IDLE) && req0_valid && !grant_id;
   assign req1_ready = rst_n && (state == IDLE) && req1_valid && grant_id;
   assign accept     = req0_ready || req1_ready;

`ifdef ADD_SEQ_SUB_EN
   logic sub_q;

   assign sub_in = ((grant_id ? req1_op : req0_op) == OP_SUB);
   assign add_y  = b_q[7:0] ^ {8{sub_q}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                         sub_q <= 1'b0;
      else if (state == IDLE && accept)   sub_q <= sub_in;
   end
`else
   logic unused_op;

   assign sub_in    = 1'b0;
   assign unused_op = req0_op ^ req1_op;
   assign add_y     = b_q[7:0];
`endif

   conditional_sum_adder u_adder (
      .x  (a_q[7:0]),
      .y  (add_y),
      .c0 (carry_q),
      .S  (add_s),
      .c8 (add_c8)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         prio      <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         sum_q     <= '0;
         carry_q   <= 1'b0;
         id_q      <= 1'b0;
         cnt       <= '0;
         rsp_valid <= 1'b0;
         rsp_sum   <= '0;
         rsp_cout  <= 1'b0;
         rsp_id    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state   <= RUN;
                  prio    <= ~grant_id;
                  id_q    <= grant_id;
                  a_q     <= grant_id ? req1_a : req0_a;
                  b_q     <= grant_id ? req1_b : req0_b;
                  carry_q <= sub_in;
                  cnt     <= CNT_LAST;
               end
            end
            RUN: begin
               a_q     <= a_q >> 8;
               b_q     <= b_q >> 8;
               sum_q   <= {add_s, sum_q[W-1:8]};
               carry_q <= add_c8;
               if (cnt == '0) state <= DONE;
               else           cnt   <= cnt - 1'b1;
            end
            DONE: begin
               // First DONE cycle loads the output register; the handshake follows.
               if (!rsp_valid) begin
                  rsp_valid <= 1'b1;
                  rsp_sum   <= sum_q;
                  rsp_cout  <= carry_q;
                  rsp_id    <= id_q;
               end else if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_add_sequencer.sv
// Scoreboard bench for add_sequencer: stimulus queues expected responses,
// a negedge monitor checks each response, its latency and its stability.
module tb_add_sequencer;
   import add_seq_pkg::*;

   localparam int NB = 4;

   typedef struct {
      logic [31:0] sum;
      logic        cout;
      logic        id;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        req0_valid, req0_ready, req0_op;
   logic        req1_valid, req1_ready, req1_op;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        rsp_valid, rsp_ready, rsp_cout, rsp_id;
   logic [31:0] rsp_sum;

   exp_t        exp_q[$];
   int          acc_q[$];
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   logic        seen = 1'b0;
   logic [31:0] held_sum;
   logic        held_cout, held_id;

   add_sequencer #(.NUM_BYTES(NB)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_op    (req0_op),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_op    (req1_op),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_sum    (rsp_sum),
      .rsp_cout   (rsp_cout),
      .rsp_id     (rsp_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %0s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic expect_rsp(input logic [31:0] sum, input logic cout, input logic id);
      exp_q.push_back('{sum, cout, id});
   endtask

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic send(input int n, input logic [31:0] a, input logic [31:0] b, input logic op);
      logic ok;
      ok = 1'b0;
      if (n == 0) begin
         req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
      end else begin
         req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
      end
      for (int i = 0; i < 200 && !ok; i++) begin
         #1;
         ok = (n == 0) ? req0_ready : req1_ready;
         @(negedge clk);
      end
      if (n == 0) req0_valid = 1'b0;
      else        req1_valid = 1'b0;
      if (!ok) check("accept_timeout", 32'(ok), 32'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   // Monitor: records accepts and checks every response against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      #2;
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) acc_q.push_back(cyc + 1);
      if (rsp_valid) begin
         if (!seen) begin
            if (exp_q.size() == 0) begin
               check("spurious_rsp", 32'(rsp_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("rsp_sum", rsp_sum, e.sum);
               check("rsp_cout", 32'(rsp_cout), 32'(e.cout));
               check("rsp_id", 32'(rsp_id), 32'(e.id));
               if (acc_q.size() > 0) check("latency", 32'(cyc - acc_q.pop_front()), 32'(NB + 1));
               else                  check("accept_record", acc_q.size(), 1);
            end
            seen      = 1'b1;
            held_sum  = rsp_sum;
            held_cout = rsp_cout;
            held_id   = rsp_id;
         end else begin
            check("hold_sum", rsp_sum, held_sum);
            check("hold_cout", 32'(rsp_cout), 32'(held_cout));
            check("hold_id", 32'(rsp_id), 32'(held_id));
         end
         if (rsp_ready) seen = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int highs;
      rst_n = 1'b0;
      req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_op = OP_ADD;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = OP_ADD;
      rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_req0_ready", 32'(req0_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_sum", rsp_sum, 32'd0);
      check("rst_rsp_cout_id", {30'd0, rsp_cout, rsp_id}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Both valid straight out of reset: req0 first, then req1, then req0 again.
      expect_rsp(32'h0000_0030, 1'b0, 1'b0);
      expect_rsp(32'h0000_0000, 1'b1, 1'b1);
      fork
         send(0, 32'h0000_0010, 32'h0000_0020, OP_ADD);
         send(1, 32'h8000_0000, 32'h8000_0000, OP_ADD);
      join
      expect_rsp(32'hFFFF_FFFF, 1'b0, 1'b0);
      expect_rsp(32'h0001_0000, 1'b0, 1'b1);
      fork
         send(0, 32'hAAAA_AAAA, 32'h5555_5555, OP_ADD);
         send(1, 32'h0000_FFFF, 32'h0000_0001, OP_ADD);
      join
      drain();

      expect_rsp(32'h0000_0000, 1'b1, 1'b0);
      send(0, 32'hFFFF_FFFF, 32'h0000_0001, OP_ADD);
      drain();

      // Response back-pressure with req1 pending.
      expect_rsp(32'h0000_0007, 1'b0, 1'b0);
      expect_rsp(32'h3333_3333, 1'b0, 1'b1);
      rsp_ready = 1'b0;
      send(0, 32'h0000_0003, 32'h0000_0004, OP_ADD);
      fork
         send(1, 32'h1111_1111, 32'h2222_2222, OP_ADD);
         begin
            for (int i = 0; i < 20 && !rsp_valid; i++) begin
               @(negedge clk);
               #1;
            end
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            for (int k = 0; k < 3; k++) begin
               check("stall_req1_ready", 32'(req1_ready), 32'd0);
               @(negedge clk);
               #1;
            end
            check("stall_rsp_still_valid", 32'(rsp_valid), 32'd1);
            check("handshake_req1_ready", 32'(req1_ready), 32'd0);
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            check("post_hs_rsp_valid", 32'(rsp_valid), 32'd0);
            check("post_hs_req1_ready", 32'(req1_ready), 32'd1);
         end
      join
      drain();

`ifdef ADD_SEQ_SUB_EN
      expect_rsp(32'hFFFF_FFFE, 1'b0, 1'b0);
`else
      expect_rsp(32'h0000_000C, 1'b0, 1'b0);
`endif
      send(0, 32'h0000_0005, 32'h0000_0007, OP_SUB);
      drain();

      // Abort in RUN cycle 2: no response, outputs cleared, then a clean request.
      send(1, 32'h0101_0101, 32'h0202_0202, OP_ADD);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      req0_valid = 1'b1;
      #1;
      check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      check("abort_req0_ready", 32'(req0_ready), 32'd0);
      check("abort_rsp_sum", rsp_sum, 32'd0);
      check("abort_rsp_cout_id", {30'd0, rsp_cout, rsp_id}, 32'd0);
      @(negedge clk);
      acc_q.delete();
      rst_n = 1'b1;
      req0_valid = 1'b0;
      highs = 0;
      for (int i = 0; i < 12; i++) begin
         #1;
         if (rsp_valid) highs++;
         @(negedge clk);
      end
      check("abort_no_rsp", highs, 0);

      expect_rsp(32'h2222_2221, 1'b0, 1'b0);
      send(0, 32'h1234_5678, 32'h0FED_CBA9, OP_ADD);
      drain();

      check("scoreboard_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/add_sequencer.md
ADD_SEQUENCER -- requirements
Module: add_sequencer

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 4, the operand width in bytes (W = 8*NUM_BYTES, legal 2..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports reqN_valid, input, 1, and reqN_ready, output, 1, the request handshake of requester N (N = 0, 1).
REQ-005 SHALL have ports reqN_a and reqN_b, input, W, the operands of requester N.
REQ-006 SHALL have port reqN_op, input, 1, the operation of requester N: 0 = add, 1 = subtract.
REQ-007 SHALL have ports rsp_valid, output, 1, and rsp_ready, input, 1, the response handshake.
REQ-008 SHALL have port rsp_sum, output, W, the result.
REQ-009 SHALL have port rsp_cout, output, 1, the final carry (for subtract, 1 = no borrow).
REQ-010 SHALL have port rsp_id, output, 1, the index of the requester that owns the response.

Function
REQ-011 SHALL time-share one 8-bit adder between both requesters, processing one byte per cycle, LSB first.
REQ-012 SHALL implement FSM states IDLE, RUN and DONE, with transitions IDLE->RUN on accept, RUN->DONE after NUM_BYTES cycles, and DONE->IDLE on rsp_valid&&rsp_ready.
REQ-013 SHALL assert reqN_ready only in IDLE and only for the granted requester, so that at most one ready is high per cycle.
REQ-014 SHALL grant a lone valid requester; when both are valid, it SHALL grant the requester not served last (round-robin).
REQ-015 SHALL update the round-robin pointer only on an accept (valid&&ready).
REQ-016 SHALL register the operands, op and id on accept; later changes to the request inputs SHALL NOT affect the operation in flight.
REQ-017 SHALL initialise the carry register on accept to 0 for add and to 1 for subtract; in RUN cycle k it SHALL add byte k of a to byte k of b (inverted for subtract) plus the carry, then store the sum byte and the new carry.
REQ-018 SHALL, for an accept at edge T, assert rsp_valid from edge T+NUM_BYTES+1; latency = NUM_BYTES+1 cycles.
REQ-019 SHALL hold rsp_valid, rsp_sum, rsp_cout and rsp_id stable while rsp_valid && !rsp_ready.
REQ-020 SHALL accept no new request from DONE until the response handshake completes, i.e. no back-to-back accept in the same cycle as rsp handshake; IDLE is re-entered first.
REQ-021 SHALL ignore valid requests arriving during RUN or DONE; they remain pending with ready low.
REQ-022 SHALL produce modular arithmetic only: rsp_sum = (a op b) mod 2^W, and rsp_cout = carry out of bit W-1.

Reset
REQ-023 SHALL, while rst_n = 0 (asynchronously, including mid-RUN or in DONE), force state to IDLE and all outputs to 0.
REQ-024 SHALL, while rst_n = 0, clear the carry and result registers and set the round-robin pointer to favour requester 0.
REQ-025 SHALL discard any operation aborted by reset and produce no response for it.

Configuration
REQ-026 SHALL, with ADD_SEQ_SUB_EN defined, honour reqN_op as specified in REQ-017.
REQ-027 SHALL, with ADD_SEQ_SUB_EN undefined, ignore reqN_op, treat every request as add, and omit the operand inverter; ports are unchanged.

Structure
REQ-028 SHALL place the FSM state enum, the op encodings (OP_ADD = 0, OP_SUB = 1) and the NUM_BYTES default in package add_seq_pkg.
REQ-029 SHALL instantiate exactly one sub-module, conditional_sum_adder (x, y, c0 -> S, c8), as the shared byte adder; there SHALL be no other arithmetic datapath.

Verification
REQ-030 Bench SHALL cover: req0 add 0xFFFFFFFF + 0x00000001 -> rsp_sum 0x00000000, rsp_cout 1, rsp_id 0, rsp_valid 5 cycles after accept.
REQ-031 Bench SHALL cover: both valid in the first cycle after reset -> req0 served first, then req1; a third simultaneous request -> req0 served again.
REQ-032 Bench SHALL cover: rsp_ready held low for 3 cycles with req1 valid -> response stable, req1_ready stays 0, req1 accepted only after the handshake and return to IDLE.
REQ-033 Bench SHALL cover: with ADD_SEQ_SUB_EN, subtract 0x00000005 - 0x00000007 -> rsp_sum 0xFFFFFFFE, rsp_cout 0; without it, the same stimulus -> rsp_sum 0x0000000C, rsp_cout 0.
REQ-034 Bench SHALL cover: rst_n pulsed low in RUN cycle 2 -> rsp_valid never asserts for that request, outputs 0, and the next request completes correctly.
REQ-035 Bench SHALL cover: 0x12345678 + 0x0FEDCBA9 -> rsp_sum 0x22222221, rsp_cout 0.
